// File: rtl/me_unit.sv
// Memory-access stage: holds one instruction from EX, waits for its data-SRAM
// response, extracts load data and hands the result to WB; drives the ID forwarding bus.
module me_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_to_me_valid,
   output logic        me_allowin,
   input  logic [74:0] ex_to_me_bus,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   output logic        me_to_wb_valid,
   input  logic        wb_allowin,
   output logic [69:0] me_to_wb_bus,
   output logic        me_fwd_we,
   output logic [4:0]  me_fwd_dest,
   output logic [31:0] me_fwd_data,
   output logic        me_fwd_stall
);

   logic        me_valid_reg;
   logic [74:0] ex_bus_reg;
   logic        data_got_reg;
   logic [31:0] rdata_buf_reg;

   logic [31:0] pc;
   logic        rf_we;
   logic [4:0]  dest;
   logic        mem_req;
   logic        is_load;
   logic [2:0]  ld_op;
   logic [31:0] alu_result;

   assign pc         = ex_bus_reg[74:43];
   assign rf_we      = ex_bus_reg[42];
   assign dest       = ex_bus_reg[41:37];
   assign mem_req    = ex_bus_reg[36];
   assign is_load    = ex_bus_reg[35];
   assign ld_op      = ex_bus_reg[34:32];
   assign alu_result = ex_bus_reg[31:0];

   logic ready_go;
   logic transfer;

   assign ready_go       = !mem_req || data_got_reg || data_sram_data_ok;
   assign me_to_wb_valid = me_valid_reg && ready_go;
   assign me_allowin     = !me_valid_reg || (ready_go && wb_allowin);
   assign transfer       = me_to_wb_valid && wb_allowin;

   always_ff @(posedge clk) begin
      if (!reset) begin
         me_valid_reg  <= 1'b0;
         ex_bus_reg    <= '0;
         data_got_reg  <= 1'b0;
         rdata_buf_reg <= '0;
      end else begin
         if (me_allowin) begin
            me_valid_reg <= ex_to_me_valid;
         end
         if (ex_to_me_valid && me_allowin) begin
            ex_bus_reg <= ex_to_me_bus;
         end
         // A response that arrives while WB is stalled must be kept, the SRAM will not repeat it.
         if (transfer) begin
            data_got_reg <= 1'b0;
         end else if (me_valid_reg && mem_req && !data_got_reg && data_sram_data_ok && !wb_allowin) begin
            data_got_reg  <= 1'b1;
            rdata_buf_reg <= data_sram_rdata;
         end
      end
   end

   logic [31:0] eff_rdata;
   logic [7:0]  rd_byte [4];
   logic [15:0] rd_half [2];

   assign eff_rdata = data_got_reg ? rdata_buf_reg : data_sram_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte
         assign rd_byte[gi] = eff_rdata[gi*8 +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half
         assign rd_half[gi] = eff_rdata[gi*16 +: 16];
      end
   endgenerate

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_value;
   logic [31:0] final_result;

   assign ld_byte = rd_byte[alu_result[1:0]];
   assign ld_half = rd_half[alu_result[1]];

   always_comb begin
      ld_value = eff_rdata;
      case (ld_op)
         3'b001:  ld_value = {{24{ld_byte[7]}}, ld_byte};
         3'b010:  ld_value = {{16{ld_half[15]}}, ld_half};
         3'b011:  ld_value = {24'd0, ld_byte};
         3'b100:  ld_value = {16'd0, ld_half};
         default: ld_value = eff_rdata;
      endcase
   end

   assign final_result = is_load ? ld_value : alu_result;
   assign me_to_wb_bus = {pc, rf_we, dest, final_result};

   assign me_fwd_we    = me_valid_reg && rf_we;
   assign me_fwd_dest  = dest;
   assign me_fwd_data  = final_result;
   assign me_fwd_stall = me_valid_reg && is_load && !data_got_reg && !data_sram_data_ok;

endmodule

// File: tb/tb_me_unit.sv
// Scoreboard bench for me_unit: a cycle-level EX/SRAM/WB environment issues instructions,
// pushes the expected WB bus at acceptance, and a monitor checks every cycle.
module tb_me_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_to_me_valid;
   logic        me_allowin;
   logic [74:0] ex_to_me_bus;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        me_to_wb_valid;
   logic        wb_allowin;
   logic [69:0] me_to_wb_bus;
   logic        me_fwd_we;
   logic [4:0]  me_fwd_dest;
   logic [31:0] me_fwd_data;
   logic        me_fwd_stall;

   always #5 clk = ~clk;

   me_unit dut (
      .clk               (clk),
      .reset             (reset),
      .ex_to_me_valid    (ex_to_me_valid),
      .me_allowin        (me_allowin),
      .ex_to_me_bus      (ex_to_me_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .me_to_wb_valid    (me_to_wb_valid),
      .wb_allowin        (wb_allowin),
      .me_to_wb_bus      (me_to_wb_bus),
      .me_fwd_we         (me_fwd_we),
      .me_fwd_dest       (me_fwd_dest),
      .me_fwd_data       (me_fwd_data),
      .me_fwd_stall      (me_fwd_stall)
   );

   typedef struct {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  dest;
      logic        mem_req;
      logic        is_load;
      logic [2:0]  ld_op;
      logic [31:0] alu;
      logic [31:0] rdata;
      int          delay;
   } instr_t;

   int tests = 0;
   int fails = 0;

   instr_t      ex_q[$];
   logic [69:0] sb[$];
   instr_t      cur_ex;
   instr_t      slot;
   bit          offering = 0;
   bit          slot_v = 0;
   bit          slot_got = 0;
   int          slot_wait = 0;
   bit          mon_en = 0;
   bit          rst_req = 0;
   bit          stray_force = 0;
   int          wb_force = -1;

   function automatic void check(string name, logic [69:0] act, logic [69:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic instr_t mk(logic [31:0] pc, logic mem_req, logic is_load, logic [2:0] ld_op,
                                 logic [31:0] alu, logic [31:0] rdata, int delay);
      instr_t t;
      t.pc = pc; t.rf_we = is_load || !mem_req; t.dest = pc[6:2];
      t.mem_req = mem_req; t.is_load = is_load; t.ld_op = ld_op;
      t.alu = alu; t.rdata = rdata; t.delay = delay;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      instr_t t;
      t.pc      = $urandom;
      t.rf_we   = 1'($urandom_range(1));
      t.dest    = 5'($urandom);
      t.mem_req = 1'($urandom_range(1));
      t.is_load = t.mem_req && ($urandom_range(3) != 0);
      t.ld_op   = 3'($urandom);
      t.alu     = $urandom;
      t.rdata   = $urandom;
      t.delay   = int'($urandom_range(4));
      return t;
   endfunction

   // Load semantics expressed arithmetically: shift the lane down, mask, then sign-extend by bias.
   function automatic logic [31:0] load_value(logic [2:0] op, logic [31:0] addr, logic [31:0] word);
      logic [31:0] b;
      logic [31:0] h;
      b = (word >> (8 * int'(addr[1:0]))) & 32'h0000_00FF;
      h = (word >> (16 * int'(addr[1]))) & 32'h0000_FFFF;
      case (op)
         3'd1:    return (b ^ 32'h80) - 32'h80;
         3'd2:    return (h ^ 32'h8000) - 32'h8000;
         3'd3:    return b;
         3'd4:    return h;
         default: return word;
      endcase
   endfunction

   function automatic logic [69:0] exp_bus(instr_t t);
      return {t.pc, t.rf_we, t.dest, t.is_load ? load_value(t.ld_op, t.alu, t.rdata) : t.alu};
   endfunction

   // One clock of the environment: decide from the model what happens at the edge, then drive.
   task automatic step();
      bit dok, wb, rst_s, rdy, xfer, allow, acc, awaiting;
      @(negedge clk);
      dok   = data_sram_data_ok;
      wb    = wb_allowin;
      rst_s = reset;
      rdy   = !slot.mem_req || slot_got || dok;
      xfer  = slot_v && rdy && wb;
      allow = !slot_v || (rdy && wb);
      acc   = ex_to_me_valid && allow;
      @(posedge clk);
      if (!rst_s) begin
         slot_v = 0; slot_got = 0; sb.delete();
      end else begin
         if (xfer) begin
            slot_v = 0; slot_got = 0;
         end else if (slot_v && slot.mem_req && dok) begin
            slot_got = 1;
         end
         if (acc) begin
            slot = cur_ex; slot_v = 1; slot_got = 0; slot_wait = cur_ex.delay;
            sb.push_back(exp_bus(cur_ex));
            offering = 0;
         end
      end
      #1;
      reset = !rst_req;
      awaiting = slot_v && slot.mem_req && !slot_got;
      data_sram_rdata = $urandom;
      data_sram_data_ok = 1'b0;
      if (awaiting) begin
         if (slot_wait == 0) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata = slot.rdata;
         end else begin
            slot_wait--;
         end
      end else if (!slot_v || !slot.mem_req) begin
         data_sram_data_ok = stray_force || ($urandom_range(7) == 0);
      end
      wb_allowin = (wb_force >= 0) ? (wb_force != 0) : ($urandom_range(3) != 0);
      if (!offering && ex_q.size() > 0 && (!ex_q[0].mem_req || !awaiting)) begin
         cur_ex = ex_q.pop_front();
         offering = 1;
      end
      ex_to_me_valid = offering && !rst_req;
      ex_to_me_bus = offering ? {cur_ex.pc, cur_ex.rf_we, cur_ex.dest, cur_ex.mem_req, cur_ex.is_load,
                                 cur_ex.ld_op, cur_ex.alu}
                              : {11'($urandom), $urandom, $urandom};
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Monitor: compares handshake, forwarding and the WB bus against the model every cycle.
   initial begin : monitor
      logic [69:0] prev_bus;
      bit prev_hold;
      bit rdy, ev;
      prev_hold = 0;
      prev_bus = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            rdy = !slot.mem_req || slot_got || data_sram_data_ok;
            ev  = slot_v && rdy;
            check("me_to_wb_valid", 70'(me_to_wb_valid), 70'(ev));
            check("me_allowin", 70'(me_allowin), 70'(!slot_v || (rdy && wb_allowin)));
            check("me_fwd_we", 70'(me_fwd_we), 70'(slot_v && slot.rf_we));
            check("me_fwd_stall", 70'(me_fwd_stall),
                  70'(slot_v && slot.is_load && !slot_got && !data_sram_data_ok));
            if (slot_v) check("me_fwd_dest", 70'(me_fwd_dest), 70'(slot.dest));
            if (ev) begin
               if (sb.size() == 0) begin
                  check("scoreboard_nonempty", 70'(0), 70'(1));
               end else begin
                  check("me_to_wb_bus", me_to_wb_bus, sb[0]);
                  check("me_fwd_data", 70'(me_fwd_data), 70'(sb[0][31:0]));
                  if (prev_hold) check("bus_stable", me_to_wb_bus, prev_bus);
                  if (wb_allowin && reset) void'(sb.pop_front());
               end
            end
            prev_hold = ev && !wb_allowin && reset;
            prev_bus  = me_to_wb_bus;
         end
      end
   end

   initial begin
      reset = 1'b0; ex_to_me_valid = 1'b0; ex_to_me_bus = '0;
      data_sram_data_ok = 1'b0; data_sram_rdata = '0; wb_allowin = 1'b1;
      slot = mk(0, 0, 0, 0, 0, 0, 0);
      cur_ex = slot;
      rst_req = 1;
      run(3);
      rst_req = 0;
      wb_force = 1;
      run(1);
      #2;
      check("reset_bus", me_to_wb_bus, 70'(0));
      check("reset_wb_valid", 70'(me_to_wb_valid), 70'(0));
      check("reset_allowin", 70'(me_allowin), 70'(1));
      check("reset_fwd_we", 70'(me_fwd_we), 70'(0));
      check("reset_fwd_stall", 70'(me_fwd_stall), 70'(0));
      mon_en = 1;

      // Non-memory stream at full rate
      for (int i = 0; i < 3; i++) ex_q.push_back(mk(32'h100 + 4*i, 0, 0, 0, 32'hA000_0000 + i, 0, 0));
      run(6);
      // LB at 0x1003, response two cycles after entry
      ex_q.push_back(mk(32'h200, 1, 1, 3'd1, 32'h0000_1003, 32'h80FF_1234, 2));
      run(6);
      // LHU at 0x2002, response under a WB stall released three cycles later
      wb_force = 0;
      ex_q.push_back(mk(32'h300, 1, 1, 3'd4, 32'h0000_2002, 32'hBEEF_0000, 0));
      run(5);
      wb_force = 1;
      run(3);
      // Store with a four-cycle acknowledge
      ex_q.push_back(mk(32'h400, 1, 0, 3'd0, 32'h0000_5550, 32'h1234_5678, 4));
      run(8);
      // Reset while a load waits, then a stray response, then a normal instruction
      ex_q.push_back(mk(32'h500, 1, 1, 3'd0, 32'h0000_6000, 32'hCAFE_F00D, 20));
      run(4);
      rst_req = 1;
      run(1);
      rst_req = 0;
      stray_force = 1;
      run(1);
      stray_force = 0;
      ex_q.push_back(mk(32'h600, 0, 0, 3'd0, 32'h0BAD_F00D, 0, 0));
      run(4);

      // Randomised traffic with WB back-pressure and occasional resets
      wb_force = -1;
      for (int i = 0; i < 4000; i++) begin
         if (ex_q.size() == 0 && $urandom_range(2) != 0) ex_q.push_back(rand_instr());
         rst_req = ($urandom_range(499) == 0);
         step();
      end
      rst_req = 0;

      wb_force = 1;
      for (int i = 0; i < 100; i++) begin
         if (ex_q.size() == 0 && !offering && !slot_v && sb.size() == 0) break;
         step();
      end
      check("drain_timeout", 70'(ex_q.size() + sb.size() + int'(offering) + int'(slot_v)), 70'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
